// File: rtl/imem_pkg.sv
//==============================================================================
// Module      : imem_pkg
// Description : Shared types, default sizes and parity helper for the
//               pipelined instruction memory.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package imem_pkg;

    localparam int c_imem_data_w    = 16;
    localparam int c_imem_addr_w    = 8;
    localparam int c_imem_par_max_w = 64;

    typedef enum logic [0:0] {
        IMEM_CLEAR = 1'b0,
        IMEM_RUN   = 1'b1
    } imem_state_t;

    // Even parity: the returned bit makes the total count of ones even.
    // Callers zero-extend narrower words, which leaves the XOR unchanged.
    function automatic logic imem_parity(input logic [c_imem_par_max_w-1:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_ram_array.sv
//==============================================================================
// Module      : imem_ram_array
// Description : Simple dual-port RAM, one write port and one registered read
//               port. No reset on contents or read register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_ram_array #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [WIDTH-1:0] r_mem [c_depth];
    logic [WIDTH-1:0] r_rdata;

    // Read register only moves on a read enable, so it doubles as the
    // stall-stable response holding register.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/instr_mem_pipelined.sv
//==============================================================================
// Module      : instr_mem_pipelined
// Description : Instruction memory with load port, pipelined fetch port
//               (latency 1, stall-safe) and post-reset clear sequencer.
//               Optional stored parity: define INSTR_MEM_PARITY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_mem_pipelined
    import imem_pkg::*;
#(
    parameter int                 DATA_W   = c_imem_data_w,
    parameter int                 ADDR_W   = c_imem_addr_w,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              fetch_req_valid,
    output logic              fetch_req_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_rsp_valid,
    input  logic              fetch_rsp_ready,
    output logic [DATA_W-1:0] fetch_rsp_data,
    output logic [ADDR_W-1:0] fetch_rsp_addr,
    output logic              init_done,
    output logic              parity_err
);

`ifdef INSTR_MEM_PARITY_EN
    localparam int c_store_w = DATA_W + 1;
`else
    localparam int c_store_w = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    imem_state_t       r_state;
    logic [ADDR_W-1:0] r_clear_ptr;
    logic              r_rsp_valid;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic              r_rsp_from_ram;
    logic [DATA_W-1:0] r_hold_data;

    logic                 w_run;
    logic                 w_load_acc;
    logic                 w_fetch_acc;
    logic                 w_bypass;
    logic                 w_we;
    logic [ADDR_W-1:0]    w_waddr;
    logic [DATA_W-1:0]    w_wdata;
    logic [c_store_w-1:0] w_wstore;
    logic [c_store_w-1:0] w_rstore;

    assign w_run           = (r_state == IMEM_RUN);
    assign load_ready      = w_run;
    assign init_done       = w_run;
    assign fetch_req_ready = w_run & (~r_rsp_valid | fetch_rsp_ready);

    assign w_load_acc  = load_valid & load_ready;
    assign w_fetch_acc = fetch_req_valid & fetch_req_ready;
    assign w_bypass    = w_load_acc & w_fetch_acc & (load_addr == fetch_addr);

    // Clear owns the write port until the last word is written.
    assign w_we    = ~w_run | w_load_acc;
    assign w_waddr = w_run ? load_addr : r_clear_ptr;
    assign w_wdata = w_run ? load_data : NOP_WORD;

`ifdef INSTR_MEM_PARITY_EN
    assign w_wstore = {imem_parity(c_imem_par_max_w'(w_wdata)), w_wdata};
`else
    assign w_wstore = w_wdata;
`endif

    imem_ram_array #(
        .WIDTH  (c_store_w),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wstore),
        .re    (w_fetch_acc & ~w_bypass),
        .raddr (fetch_addr),
        .rdata (w_rstore)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IMEM_CLEAR;
            r_clear_ptr    <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_addr     <= '0;
            r_rsp_from_ram <= 1'b0;
            r_hold_data    <= '0;
        end else begin
            case (r_state)
                IMEM_CLEAR: begin
                    r_clear_ptr <= r_clear_ptr + ADDR_W'(1);
                    if (r_clear_ptr == c_last_addr) begin
                        r_state <= IMEM_RUN;
                    end
                end
                IMEM_RUN: r_state <= IMEM_RUN;
                default:  r_state <= IMEM_CLEAR;
            endcase

            // Bypassed words live in r_hold_data; RAM reads stay in the RAM register.
            if (w_fetch_acc) begin
                r_rsp_valid    <= 1'b1;
                r_rsp_addr     <= fetch_addr;
                r_rsp_from_ram <= ~w_bypass;
                if (w_bypass) begin
                    r_hold_data <= load_data;
                end
            end else if (fetch_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign fetch_rsp_valid = r_rsp_valid;
    assign fetch_rsp_addr  = r_rsp_addr;
    assign fetch_rsp_data  = r_rsp_from_ram ? w_rstore[DATA_W-1:0] : r_hold_data;

`ifdef INSTR_MEM_PARITY_EN
    assign parity_err = r_rsp_from_ram &
                        (imem_parity(c_imem_par_max_w'(w_rstore[DATA_W-1:0])) ^ w_rstore[DATA_W]);
`else
    assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire
